// File: rtl/spi_adxl362_responder.sv
// SPI mode-0 responder modelling a small ADXL362-style 64 x 8 register file.
// Define SPI_RESP_BURST_EN to enable address auto-increment across data bytes.
module spi_adxl362_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       active,
  output logic       wr_valid,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data
);

`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam logic [7:0] CMD_WRITE       = 8'h0A;
  localparam logic [7:0] CMD_READ        = 8'h0B;
  localparam logic [5:0] SOFT_RESET_ADDR = 6'h1F;
  localparam logic [7:0] SOFT_RESET_KEY  = 8'h52;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  function automatic logic [7:0] reset_val(input logic [5:0] a);
    case (a)
      6'h00:   return 8'hAD;
      6'h01:   return 8'h1D;
      6'h02:   return 8'hF2;
      6'h03:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flushed;
  logic       sclk_d, armed;
  logic       sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] rx_byte, tx, rd_byte;
  logic       is_read, oor;
  logic [5:0] addr;
  logic [7:0] regs [64];

  logic       byte_done, take_cmd, take_addr, load_rd, capture_wr, step_addr;
  logic [5:0] rd_addr;
  logic       rd_oor;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rx_byte   = {shift, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign active    = ~cs_s;
  assign rd_byte   = rd_oor ? 8'h00 : regs[rd_addr];

  // 'armed' blocks a transaction that was already in flight when rst hit:
  // cs must be seen high through a fully flushed synchronizer first.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      flushed   <= '0;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      flushed   <= {flushed[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      armed     <= armed | (flushed[SYNC_STAGES-1] & cs_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (armed && !cs_s) state_nxt = CMD;
      CMD:     if (byte_done) state_nxt = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ADDR : IGNORE;
      ADDR:    if (byte_done) state_nxt = DATA;
      DATA:    if (byte_done && !BURST) state_nxt = IGNORE;
      IGNORE:  ;
      default: state_nxt = IDLE;
    endcase
    if (cs_s) state_nxt = IDLE;
  end

  always_comb begin
    take_cmd   = 1'b0;
    take_addr  = 1'b0;
    load_rd    = 1'b0;
    capture_wr = 1'b0;
    step_addr  = 1'b0;
    rd_addr    = addr + 6'd1;
    rd_oor     = oor;
    unique case (state)
      CMD:  take_cmd = byte_done;
      ADDR: begin
        take_addr = byte_done;
        load_rd   = byte_done && is_read;
        rd_addr   = rx_byte[5:0];
        rd_oor    = |rx_byte[7:6];
      end
      DATA: begin
        load_rd    = byte_done && is_read && BURST;
        capture_wr = byte_done && !is_read && !oor;
        step_addr  = byte_done && BURST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= '0;
      miso     <= 1'b0;
      is_read  <= 1'b0;
      oor      <= 1'b0;
      addr     <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (state == IDLE) begin
        bit_cnt <= '0;
        shift   <= '0;
        tx      <= '0;
        miso    <= 1'b0;
      end else begin
        if (sclk_rise) begin
          shift   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (sclk_fall) begin
          miso <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
        if (load_rd) tx <= rd_byte;
        if (take_cmd) is_read <= rx_byte[0];
        if (take_addr) begin
          addr <= rx_byte[5:0];
          oor  <= |rx_byte[7:6];
        end
        if (step_addr) addr <= addr + 6'd1;
        if (capture_wr) begin
          wr_valid <= 1'b1;
          wr_addr  <= addr;
          wr_data  <= rx_byte;
        end
      end
    end
  end

  // The write lands in the cycle wr_valid is high; a soft-reset key wins over the write itself.
  always_ff @(posedge clk) begin
    // NOTE: the register file has defined reset contents, so it is built from resettable flops, not RAM.
    if (rst || (wr_valid && wr_addr == SOFT_RESET_ADDR && wr_data == SOFT_RESET_KEY)) begin
      for (int i = 0; i < 64; i++) regs[i] <= reset_val(6'(i));
    end else if (wr_valid && wr_addr > 6'h03) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/spi_adxl362_responder.md
SPI_ADXL362_RESPONDER -- requirements
Module: spi_adxl362_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop synchronizer stages on sclk, cs and mosi (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, the system clock; every flop is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port sclk, input, 1, the SPI clock (mode 0), asynchronous to clk.
REQ-005 The block SHALL have port cs, input, 1, the active-low chip select, asynchronous to clk.
REQ-006 The block SHALL have port mosi, input, 1, serial data from the initiator, MSB first.
REQ-007 The block SHALL have port miso, output, 1, serial data to the initiator, MSB first.
REQ-008 The block SHALL have port active, output, 1, which is high while a transaction is in progress (synchronized cs low).
REQ-009 The block SHALL have port wr_valid, output, 1, a one-cycle pulse marking a committed register write.
REQ-010 The block SHALL have port wr_addr, output, 6, the address of the committed write.
REQ-011 The block SHALL have port wr_data, output, 8, the data of the committed write.

Function
REQ-012 sclk, cs and mosi SHALL each pass through SYNC_STAGES synchronizer flops; sclk edges SHALL be detected by comparing the last two synchronized samples; sclk frequency ≤ clk/8 is required.
REQ-013 The FSM SHALL have states IDLE, CMD, ADDR, DATA and IGNORE; a synchronized cs fall in IDLE SHALL move the FSM to CMD and clear the bit counter.
REQ-014 mosi SHALL be sampled on each detected sclk rising edge and shifted into an 8-bit register; the byte completes on the 8th rising edge.
REQ-015 Command byte 0x0A SHALL select a write and 0x0B SHALL select a read, moving to ADDR; any other command SHALL move to IGNORE, where miso is 0 until cs rises.
REQ-016 In ADDR, the lower 6 bits of the completed byte SHALL form the address; a nonzero value in bits [7:6] SHALL mark the transaction out-of-range, so reads return 0x00 and writes are dropped.
REQ-017 Register file: 64 x 8. Reset values: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=0x01, all others 0x00; addresses 0x00-0x03 are read-only.
REQ-018 Read: the read byte SHALL be loaded on the rising edge that completes the address (or data) byte, and bit 7 SHALL be driven on miso at the next detected sclk falling edge; subsequent bits SHALL shift on each falling edge.
REQ-019 Write: on the 8th rising edge of a data byte, the write SHALL commit in the following clk cycle, with wr_valid=1, wr_addr and wr_data valid for exactly that cycle; writes to read-only addresses SHALL still pulse wr_valid but leave the register unchanged.
REQ-020 Writing 0x52 to 0x1F SHALL restore all registers to reset values in the commit cycle, and 0x1F SHALL then read 0x00.
REQ-021 A cs rise in any state SHALL return the FSM to IDLE within SYNC_STAGES+1 cycles; a partial byte SHALL be discarded and SHALL NOT commit.
REQ-022 miso SHALL be 0 whenever the FSM is in IDLE, CMD, ADDR or IGNORE and no read bit is pending.
REQ-023 A cs rise coinciding with an 8th rising edge SHALL still commit that completed byte.

Reset
REQ-024 On rst, the block SHALL set FSM=IDLE, miso=0, active=0, wr_valid=0, wr_addr=0, wr_data=0, clear the shift registers and counters, load the register file with its reset values, and preset the synchronizers to the idle state (sclk=0, cs=1, mosi=0).
REQ-025 rst asserted mid-transaction SHALL abort the transaction; the block SHALL then wait for the next cs fall.

Configuration
REQ-026 With SPI_RESP_BURST_EN defined, after each data byte the address SHALL auto-increment (wrapping 0x3F to 0x00) and the transaction SHALL continue in DATA.
REQ-027 Without SPI_RESP_BURST_EN, after the first data byte the FSM SHALL go to IGNORE, so further reads return 0x00 and further writes are dropped.

Verification
REQ-028 The bench SHALL cover: read 0x0B,0x00 -> miso byte 0xAD; read 0x0B,0x02 -> 0xF2.
REQ-029 The bench SHALL cover: write 0x0A,0x20,0x5A, then read 0x20 -> wr_valid pulse with addr 0x20 / data 0x5A, and readback 0x5A.
REQ-030 The bench SHALL cover: write 0x52 to 0x1F after REQ-029 -> 0x20 reads 0x00 and 0x00 reads 0xAD.
REQ-031 The bench SHALL cover: burst read 0x0B,0x00 over 4 bytes -> with the macro, 0xAD,0x1D,0xF2,0x01; without it, 0xAD,0x00,0x00,0x00.
REQ-032 The bench SHALL cover: cs raised after 4 data bits of a write to 0x21 -> no wr_valid, and 0x21 stays 0x00.
REQ-033 The bench SHALL cover: command 0x0D, then any bytes -> miso stays 0 and no wr_valid.
